// File: rtl/force_release_sched_if.sv
// Bundles the requester, net-observation and net-mux signals of force_release_sched.
// slave = the scheduler, master = the sequencer/bench side.
interface force_release_sched_if #(
    parameter int N_REQ = 2,
    parameter int CNT_W = 4
);
    logic [N_REQ-1:0]       i_req;
    logic [N_REQ-1:0]       i_val;
    logic [N_REQ*CNT_W-1:0] i_hold;
    logic                   i_net;
    logic [N_REQ-1:0]       o_gnt;
    logic                   o_force;
    logic                   o_force_val;
    logic                   o_release;
    logic [N_REQ-1:0]       o_done;
    logic                   o_abort;
    logic                   o_mismatch;
    logic                   o_busy;

    modport slave (
        input  i_req, i_val, i_hold, i_net,
        output o_gnt, o_force, o_force_val, o_release, o_done, o_abort, o_mismatch, o_busy
    );

    modport master (
        output i_req, i_val, i_hold, i_net,
        input  o_gnt, o_force, o_force_val, o_release, o_done, o_abort, o_mismatch, o_busy
    );
endinterface

// File: rtl/force_release_sched.sv
// Round-robin force/release scheduler for one shared net; all outputs registered, grant visible
// the cycle after the request is sampled, force held hold+1 cycles, then a one-cycle release.
module force_release_sched #(
    parameter int N_REQ = 2,
    parameter int CNT_W = 4,
    parameter int GAP   = 1
) (
    input  logic                  i_sclk,
    input  logic                  i_srst,
    force_release_sched_if.slave  bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GAP_W = $clog2(GAP + 2);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FORCE   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_GAP     = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             first_q, first_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             force_q, force_d;
    logic             force_val_q, force_val_d;
    logic             release_q, release_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             abort_q, abort_d;
    logic             mismatch_q, mismatch_d;
    logic             busy_q, busy_d;

    logic [CNT_W-1:0] hold_arr [N_REQ];
    logic             sel_vld;
    logic [PTR_W-1:0] sel;
    logic [PTR_W-1:0] idx;

    for (genvar k = 0; k < N_REQ; k++) begin : g_hold
        assign hold_arr[k] = bus.i_hold[k*CNT_W +: CNT_W];
    end

    // First requester at or after the pointer, wrapping.
    always_comb begin
        sel_vld = 1'b0;
        sel     = '0;
        idx     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = PTR_W'((int'(ptr_q) + i) % N_REQ);
            if (!sel_vld && bus.i_req[idx]) begin
                sel_vld = 1'b1;
                sel     = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        first_d     = first_q;
        gnt_d       = gnt_q;
        force_d     = force_q;
        force_val_d = force_val_q;
        release_d   = 1'b0;
        done_d      = '0;
        abort_d     = 1'b0;
        mismatch_d  = mismatch_q;

        case (state_q)
            ST_IDLE: begin
                if (sel_vld) begin
                    state_d     = ST_FORCE;
                    win_d       = sel;
                    ptr_d       = (sel == PTR_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
                    cnt_d       = hold_arr[sel];
                    force_val_d = bus.i_val[sel];
                    force_d     = 1'b1;
                    gnt_d       = N_REQ'(1) << sel;
                    first_d     = 1'b1;
                end
            end
            ST_FORCE: begin
                first_d = 1'b0;
                // The net gets one cycle to settle before it is compared.
                if (!first_q && (bus.i_net != force_val_q)) begin
                    mismatch_d = 1'b1;
                end
                if (!bus.i_req[win_q]) begin
                    state_d   = ST_RELEASE;
                    force_d   = 1'b0;
                    gnt_d     = '0;
                    release_d = 1'b1;
                    abort_d   = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d       = ST_RELEASE;
                    force_d       = 1'b0;
                    gnt_d         = '0;
                    release_d     = 1'b1;
                    done_d[win_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RELEASE: begin
                if (GAP > 0) begin
                    state_d = ST_GAP;
                    gap_d   = GAP_W'(GAP - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_sclk or negedge i_srst) begin
        if (!i_srst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            first_q     <= 1'b0;
            gnt_q       <= '0;
            force_q     <= 1'b0;
            force_val_q <= 1'b0;
            release_q   <= 1'b0;
            done_q      <= '0;
            abort_q     <= 1'b0;
            mismatch_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            first_q     <= first_d;
            gnt_q       <= gnt_d;
            force_q     <= force_d;
            force_val_q <= force_val_d;
            release_q   <= release_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            mismatch_q  <= mismatch_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.o_gnt       = gnt_q;
    assign bus.o_force     = force_q;
    assign bus.o_force_val = force_val_q;
    assign bus.o_release   = release_q;
    assign bus.o_done      = done_q;
    assign bus.o_abort     = abort_q;
    assign bus.o_mismatch  = mismatch_q;
    assign bus.o_busy      = busy_q;
endmodule

// File: tb/tb_force_release_sched.sv
// Directed bench for force_release_sched (N_REQ=2, CNT_W=4, GAP=1); expectations are hand-derived.
module tb_force_release_sched;
    logic clk;
    logic rst_n;
    logic net_follow;
    logic net_fix;
    int   n_cmp;
    int   n_err;

    force_release_sched_if #(.N_REQ(2), .CNT_W(4)) bus ();

    force_release_sched #(.N_REQ(2), .CNT_W(4), .GAP(1)) dut (
        .i_sclk (clk),
        .i_srst (rst_n),
        .bus    (bus)
    );

    assign bus.i_net = net_follow ? bus.o_force_val : net_fix;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts consecutive cycles with o_force high, starting from the current one.
    task automatic count_force(output int n);
        n = 0;
        for (int i = 0; i < 64 && bus.o_force; i++) begin
            n++;
            tick();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        bus.i_req = '0; bus.i_val = '0; bus.i_hold = '0;
        net_follow = 1'b1; net_fix = 1'b0;
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({bus.o_gnt, bus.o_force, bus.o_force_val, bus.o_release, bus.o_done,
             bus.o_abort, bus.o_mismatch, bus.o_busy} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got gnt=%b force=%b fval=%b rel=%b done=%b abort=%b mis=%b busy=%b want all 0",
                     bus.o_gnt, bus.o_force, bus.o_force_val, bus.o_release, bus.o_done,
                     bus.o_abort, bus.o_mismatch, bus.o_busy);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({bus.o_busy, bus.o_force} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_idle: got busy=%b force=%b want 0 0", bus.o_busy, bus.o_force);
        end
    endtask

    task automatic test_single();
        int n;
        bus.i_val = 2'b01; bus.i_hold = 8'h03; bus.i_req = 2'b01;
        tick();
        n_cmp++;
        if ({bus.o_gnt, bus.o_force, bus.o_force_val, bus.o_busy} !== 5'b01111) begin
            n_err++;
            $display("FAIL single_grant: got gnt=%b force=%b fval=%b busy=%b want 01 1 1 1",
                     bus.o_gnt, bus.o_force, bus.o_force_val, bus.o_busy);
        end
        bus.i_hold = 8'h0F;
        count_force(n);
        n_cmp++;
        if (n !== 4) begin
            n_err++;
            $display("FAIL single_force_len: got %0d cycles want 4", n);
        end
        n_cmp++;
        if ({bus.o_release, bus.o_done, bus.o_abort, bus.o_gnt, bus.o_force_val} !== 7'b1010001) begin
            n_err++;
            $display("FAIL single_release: got rel=%b done=%b abort=%b gnt=%b fval=%b want 1 01 0 00 1",
                     bus.o_release, bus.o_done, bus.o_abort, bus.o_gnt, bus.o_force_val);
        end
        bus.i_req = '0;
        tick();
        n_cmp++;
        if ({bus.o_release, bus.o_done, bus.o_busy} !== 4'b0001) begin
            n_err++;
            $display("FAIL single_gap: got rel=%b done=%b busy=%b want 0 00 1",
                     bus.o_release, bus.o_done, bus.o_busy);
        end
        tick();
        n_cmp++;
        if ({bus.o_busy, bus.o_mismatch} !== 2'b00) begin
            n_err++;
            $display("FAIL single_idle: got busy=%b mis=%b want 0 0", bus.o_busy, bus.o_mismatch);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_gnt  [9] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01};
        logic [1:0] exp_done [9] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
        logic       exp_rel  [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       exp_busy [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        bus.i_hold = 8'h00; bus.i_val = 2'b11; bus.i_req = 2'b11;
        for (int c = 0; c < 9; c++) begin
            tick();
            n_cmp++;
            if ({bus.o_gnt, bus.o_done, bus.o_release, bus.o_busy} !==
                {exp_gnt[c], exp_done[c], exp_rel[c], exp_busy[c]}) begin
                n_err++;
                $display("FAIL rr_cycle%0d: got gnt=%b done=%b rel=%b busy=%b want %b %b %b %b", c,
                         bus.o_gnt, bus.o_done, bus.o_release, bus.o_busy,
                         exp_gnt[c], exp_done[c], exp_rel[c], exp_busy[c]);
            end
        end
        bus.i_req = '0;
        repeat (4) tick();
    endtask

    task automatic test_abort();
        bus.i_val = 2'b01; bus.i_hold = 8'h05; bus.i_req = 2'b01;
        tick();
        tick();
        n_cmp++;
        if ({bus.o_force, bus.o_gnt} !== 3'b101) begin
            n_err++;
            $display("FAIL abort_forcing: got force=%b gnt=%b want 1 01", bus.o_force, bus.o_gnt);
        end
        bus.i_req = 2'b00;
        tick();
        n_cmp++;
        if ({bus.o_release, bus.o_abort, bus.o_done, bus.o_force, bus.o_gnt} !== 7'b1100000) begin
            n_err++;
            $display("FAIL abort_release: got rel=%b abort=%b done=%b force=%b gnt=%b want 1 1 00 0 00",
                     bus.o_release, bus.o_abort, bus.o_done, bus.o_force, bus.o_gnt);
        end
        tick();
        n_cmp++;
        if ({bus.o_release, bus.o_abort} !== 2'b00) begin
            n_err++;
            $display("FAIL abort_pulse_width: got rel=%b abort=%b want 0 0", bus.o_release, bus.o_abort);
        end
        tick();
    endtask

    task automatic test_mismatch();
        net_follow = 1'b0; net_fix = 1'b0;
        bus.i_val = 2'b01; bus.i_hold = 8'h02; bus.i_req = 2'b01;
        tick();
        tick();
        n_cmp++;
        if (bus.o_mismatch !== 1'b0) begin
            n_err++;
            $display("FAIL mis_first_unchecked: got %b want 0", bus.o_mismatch);
        end
        tick();
        n_cmp++;
        if ({bus.o_mismatch, bus.o_force} !== 2'b11) begin
            n_err++;
            $display("FAIL mis_set: got mis=%b force=%b want 1 1", bus.o_mismatch, bus.o_force);
        end
        tick();
        n_cmp++;
        if ({bus.o_release, bus.o_done, bus.o_force_val} !== 4'b1011) begin
            n_err++;
            $display("FAIL mis_release: got rel=%b done=%b fval=%b want 1 01 1",
                     bus.o_release, bus.o_done, bus.o_force_val);
        end
        bus.i_req = '0;
        repeat (3) tick();
        n_cmp++;
        if ({bus.o_mismatch, bus.o_busy, bus.o_force_val} !== 3'b101) begin
            n_err++;
            $display("FAIL mis_sticky_idle: got mis=%b busy=%b fval=%b want 1 0 1",
                     bus.o_mismatch, bus.o_busy, bus.o_force_val);
        end
        net_follow = 1'b1;
    endtask

    task automatic test_max_hold();
        int n;
        do_reset();
        bus.i_val = 2'b10; bus.i_hold = 8'hF0; bus.i_req = 2'b10;
        tick();
        n_cmp++;
        if (bus.o_gnt !== 2'b10) begin
            n_err++;
            $display("FAIL max_grant: got %b want 10", bus.o_gnt);
        end
        count_force(n);
        n_cmp++;
        if (n !== 16) begin
            n_err++;
            $display("FAIL max_force_len: got %0d cycles want 16", n);
        end
        n_cmp++;
        if ({bus.o_done, bus.o_release, bus.o_mismatch} !== 4'b1010) begin
            n_err++;
            $display("FAIL max_release: got done=%b rel=%b mis=%b want 10 1 0",
                     bus.o_done, bus.o_release, bus.o_mismatch);
        end
        bus.i_req = '0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_force();
        int rel_seen;
        bus.i_val = 2'b01; bus.i_hold = 8'h09; bus.i_req = 2'b01;
        tick();
        tick();
        n_cmp++;
        if (bus.o_force !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_forcing: got %b want 1", bus.o_force);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.o_force, bus.o_gnt, bus.o_busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL midrst_async: got force=%b gnt=%b busy=%b want 0 00 0",
                     bus.o_force, bus.o_gnt, bus.o_busy);
        end
        rel_seen = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.o_release) rel_seen++;
        end
        rst_n = 1'b1;
        bus.i_req = 2'b11;
        tick();
        if (bus.o_release) rel_seen++;
        n_cmp++;
        if (rel_seen !== 0) begin
            n_err++;
            $display("FAIL midrst_no_release: got %0d pulses want 0", rel_seen);
        end
        n_cmp++;
        if ({bus.o_gnt, bus.o_mismatch} !== 3'b010) begin
            n_err++;
            $display("FAIL midrst_ptr: got gnt=%b mis=%b want 01 0", bus.o_gnt, bus.o_mismatch);
        end
        bus.i_req = '0;
        repeat (4) tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.i_req = '0; bus.i_val = '0; bus.i_hold = '0;
        net_follow = 1'b1; net_fix = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_mismatch();
        test_max_hold();
        test_reset_mid_force();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
